ifu_fetch_queue: RTL and testbench
==================================

IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: PC and address width.
REQ-002 The block SHALL have parameter DEPTH, default 4: fetch-queue entries; power of 2, at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 0: first fetch address after reset; word-aligned.
REQ-004 The block SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port stall_pc, input, 1 bit: 1 blocks new memory requests; the output side is not blocked.
REQ-007 The block SHALL have port pc_update_control, input, 1 bit: redirect strobe.
REQ-008 The block SHALL have port pc_update_val, input, XLEN bits: redirect target.
REQ-009 The block SHALL have port imem_req_valid, output, 1 bit: fetch request.
REQ-010 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-011 The block SHALL have port imem_req_addr, output, XLEN bits: fetch address, always equal to pc.
REQ-012 The block SHALL have port imem_rsp_valid, input, 1 bit: response strobe; responses arrive in order, at least 1 cycle after acceptance.
REQ-013 The block SHALL have port imem_rsp_data, input, 32 bits: instruction word.
REQ-014 The block SHALL have port out_valid, output, 1 bit: head entry holds an instruction.
REQ-015 The block SHALL have port out_ready, input, 1 bit: decode accepts the head entry.
REQ-016 The block SHALL have port out_instr, output, 32 bits: head instruction.
REQ-017 The block SHALL have port out_pc, output, XLEN bits: PC of the head instruction.
REQ-018 The block SHALL have port pc, output, XLEN bits: next fetch address.
REQ-019 The block SHALL have port prev_pc, output, XLEN bits: PC of the most recently handed-off instruction.

Function
REQ-020 Queue entries SHALL be allocated in order, with the address stored at allocation, on the cycle a request is accepted (imem_req_valid && imem_req_ready).
REQ-021 Entries SHALL be filled in order, one per non-dropped response.
REQ-022 occupancy counts allocated entries, whether filled or not.
REQ-023 imem_req_valid SHALL equal !stall_pc && !pc_update_control && occupancy < DEPTH.
REQ-024 On request acceptance, pc SHALL become pc+XLEN'(4), wrapping modulo 2^XLEN.
REQ-025 When a request is not accepted, pc SHALL hold.
REQ-026 out_valid SHALL equal head-entry-filled && !pc_update_control.
REQ-027 out_instr and out_pc SHALL be driven from the head entry.
REQ-028 On handoff (out_valid && out_ready), the head SHALL be freed and prev_pc SHALL become out_pc.
REQ-029 Allocation and free in the same cycle SHALL leave occupancy unchanged.
REQ-030 A response arriving the cycle a head entry is freed SHALL fill its target entry normally.
REQ-031 At full occupancy (DEPTH), the block SHALL issue no request until a handoff frees an entry.
REQ-032 When the queue is empty, out_valid SHALL be 0.
REQ-033 A zero-latency bypass from the response to the output SHALL NOT exist; the earliest out_valid is the cycle after the response.
REQ-034 On a redirect (pc_update_control=1), at the clock edge:
- All entries SHALL be freed (occupancy 0, pointers reset).
- pc SHALL become {pc_update_val[XLEN-1:2], 2'b00}.
- prev_pc SHALL be unchanged.
REQ-035 On a redirect, drop_cnt SHALL become drop_cnt + (allocated-unfilled entries) - (imem_rsp_valid ? 1 : 0), counting only responses not already being dropped.
- drop_cnt width is clog2(DEPTH+1)+1.
REQ-036 While drop_cnt > 0, each imem_rsp_valid SHALL be discarded, drop_cnt SHALL decrement, and no entry SHALL fill.
REQ-037 No handoff and no request SHALL occur in a redirect cycle.
REQ-038 Back-to-back redirects SHALL each apply; the last one determines pc.
REQ-039 Requests SHALL be permitted while drop_cnt > 0.
- occupancy excludes stale requests; credit is occupancy + drop_cnt < DEPTH.
REQ-040 A response arriving with no outstanding request is illegal; the block SHALL ignore it.

Reset
REQ-041 While i_rst=0 (asynchronous):
- pc SHALL be RESET_PC.
- prev_pc SHALL be 0.
- occupancy, pointers and drop_cnt SHALL be 0.
- All fill flags SHALL be cleared.
- out_valid and imem_req_valid SHALL be 0.
REQ-042 Reset asserted mid-operation SHALL discard all entries and pending drops immediately, without waiting for a clock edge.
REQ-043 The first request SHALL be possible on the first rising edge after reset release.

Verification
REQ-044 Streaming: DEPTH=4, ready=1, 1-cycle response latency, out_ready=1 -> instructions at PCs 0,4,8,12,16 emitted in order, one per cycle after fill; prev_pc trails out_pc.
REQ-045 Full: out_ready=0, 4 requests accepted -> imem_req_valid=0 with pc=16; one handoff -> request to 16 issued the next cycle.
REQ-046 Redirect with 2 in flight: pc_update_val=0x103 -> queue empties; 2 responses dropped; next request addr=0x100, whose response yields out_pc=0x100.
REQ-047 Redirect same cycle as a response, with 1 in flight -> drop_cnt=0; the response is discarded; no stale out_valid appears.
REQ-048 stall_pc=1 for 3 cycles with 2 filled entries -> no requests; both entries still hand off; pc constant.
REQ-049 Reset mid-stream with pc=0x40 -> outputs immediately equal to RESET_PC/0/invalid; late responses after release are ignored.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// In-order instruction fetch queue: issues word-aligned fetches, buffers responses
// per entry, hands them to decode in order, and drops stale responses after redirects.

module ifu_fq_entry #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_addr,
    input  logic            fill,
    input  logic [31:0]     fill_data,
    input  logic            free,
    input  logic            flush,
    output logic            filled,
    output logic [XLEN-1:0] addr,
    output logic [31:0]     instr
);
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)     filled <= 1'b0;
        else if (flush) filled <= 1'b0;
        else if (fill)  filled <= 1'b1;
        else if (free)  filled <= 1'b0;
    end

    // Payload needs no reset; it is only observed while the fill flag is set.
    always_ff @(posedge i_clk) begin
        if (alloc) addr  <= alloc_addr;
        if (fill)  instr <= fill_data;
    end
endmodule

module ifu_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            stall_pc,
    input  logic            pc_update_control,
    input  logic [XLEN-1:0] pc_update_val,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] prev_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH + 1) + 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]   head, tail, fptr;
    logic [AW:0]   occ, unfilled;
    logic [DW-1:0] drop_cnt;
    logic          dropping, req_fire, handoff, rsp_fill, rsp_drop;

    logic [DEPTH-1:0]           filled_v;
    logic [DEPTH-1:0][XLEN-1:0] addr_v;
    logic [DEPTH-1:0][31:0]     instr_v;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign occ      = tail - head;
    assign unfilled = tail - fptr;
    assign dropping = (drop_cnt != '0);

    assign imem_req_valid = i_rst && !stall_pc && !pc_update_control &&
                            ((DW'(occ) + drop_cnt) < DW'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = filled_v[head[AW-1:0]] && !pc_update_control;
    assign out_instr = instr_v[head[AW-1:0]];
    assign out_pc    = addr_v[head[AW-1:0]];
    assign handoff   = out_valid && out_ready;

    // A response belongs to the oldest stale request first; a response landing in a
    // redirect cycle retires one of the entries that would otherwise become stale.
    assign rsp_fill = imem_rsp_valid && !dropping && !pc_update_control && (unfilled != '0);
    assign rsp_drop = imem_rsp_valid && (dropping || (pc_update_control && (unfilled != '0)));

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        ifu_fq_entry #(.XLEN(XLEN)) u_ent (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .alloc      (req_fire && (tail[AW-1:0] == AW'(i))),
            .alloc_addr (pc),
            .fill       (rsp_fill && (fptr[AW-1:0] == AW'(i))),
            .fill_data  (imem_rsp_data),
            .free       (handoff && (head[AW-1:0] == AW'(i))),
            .flush      (pc_update_control),
            .filled     (filled_v[i]),
            .addr       (addr_v[i]),
            .instr      (instr_v[i])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc       <= RESET_PC;
            prev_pc  <= '0;
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_cnt + (pc_update_control ? DW'(unfilled) : '0) - DW'(rsp_drop);
            if (pc_update_control) begin
                head <= '0;
                tail <= '0;
                fptr <= '0;
                pc   <= pc_update_val & ~XLEN'(3);
            end else begin
                if (req_fire) begin
                    tail <= tail + PTR_ONE;
                    pc   <= pc + XLEN'(4);
                end
                if (rsp_fill) fptr <= fptr + PTR_ONE;
                if (handoff) begin
                    head    <= head + PTR_ONE;
                    prev_pc <= out_pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Randomized and directed bench for ifu_fetch_queue against a queue-based reference model.

module tb_ifu_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        i_clk = 1'b0, i_rst = 1'b0;
    logic        stall_pc = 1'b0, pc_update_control = 1'b0;
    logic [31:0] pc_update_val = '0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc, pc, prev_pc;

    ifu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .stall_pc(stall_pc),
        .pc_update_control(pc_update_control), .pc_update_val(pc_update_val),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .pc(pc), .prev_pc(prev_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] addr; bit filled; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int cyc; } mreq_t;

    ent_t        q[$];     // allocated entries, oldest first
    mreq_t       mem[$];   // requests the memory still owes a response for
    int          stale;
    logic [31:0] m_pc, m_prev;
    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;
    bit          e_req_valid, e_out_valid;
    logic [31:0] e_out_pc, e_out_instr;

    task automatic model_reset();
        q.delete(); mem.delete();
        stale = 0; m_pc = RESET_PC; m_prev = '0;
    endtask

    task automatic idle_inputs();
        stall_pc = 0; pc_update_control = 0; pc_update_val = '0;
        imem_req_ready = 0; out_ready = 0; imem_rsp_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 0; idle_inputs(); model_reset();
        repeat (2) @(negedge i_clk);
        i_rst = 1;
    endtask

    // Drive one cycle's inputs at the falling edge and derive the expected outputs.
    task automatic set_inputs(input bit stall, input bit redir, input logic [31:0] rval,
                              input bit rdy, input bit ordy, input bit rsp_en, input bit force_rsp);
        stall_pc = stall; pc_update_control = redir; pc_update_val = rval;
        imem_req_ready = rdy; out_ready = ordy;
        imem_rsp_valid = 0; imem_rsp_data = $urandom;
        if (rsp_en && mem.size() > 0 && mem[0].cyc < cyc) begin
            imem_rsp_valid = 1; mem.delete(0);
        end
        if (force_rsp) imem_rsp_valid = 1;
        e_req_valid = !stall && !redir && (q.size() + stale < DEPTH);
        e_out_valid = 0; e_out_pc = '0; e_out_instr = '0;
        if (q.size() > 0) begin
            e_out_valid = !redir && q[0].filled;
            e_out_pc = q[0].addr; e_out_instr = q[0].instr;
        end
        #1;
    endtask

    task automatic advance();
        bit acc, ho;
        int unf;
        acc = e_req_valid && imem_req_ready;
        ho  = e_out_valid && out_ready;
        if (pc_update_control) begin
            unf = 0;
            foreach (q[i]) if (!q[i].filled) unf++;
            if (imem_rsp_valid) begin
                if (stale > 0) stale--;
                else if (unf > 0) unf--;
            end
            stale += unf;
            q.delete();
            m_pc = {pc_update_val[31:2], 2'b00};
        end else begin
            if (imem_rsp_valid) begin
                if (stale > 0) stale--;
                else begin
                    for (int i = 0; i < q.size(); i++)
                        if (!q[i].filled) begin
                            q[i].filled = 1; q[i].instr = imem_rsp_data; break;
                        end
                end
            end
            if (ho) begin m_prev = q[0].addr; q.delete(0); end
            if (acc) begin
                q.push_back('{m_pc, 1'b0, 32'h0});
                mem.push_back('{m_pc, cyc});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst = 0; idle_inputs(); model_reset();
        imem_req_ready = 1; #1;
        n_chk++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        n_chk++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", pc, RESET_PC); end
        n_chk++; if (prev_pc !== 32'h0) begin n_fail++; $display("FAIL rst_prev_pc got=%h exp=0", prev_pc); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        @(negedge i_clk); i_rst = 1;
        set_inputs(0, 0, 0, 1, 1, 0, 0);
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_fail++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
        advance();
        n_chk++; if (pc !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL first_pc got=%h exp=%h", pc, RESET_PC + 32'd4); end
    endtask

    task automatic test_streaming();
        logic [31:0] hpc[$];
        int hcyc[$];
        int start;
        do_reset();
        start = cyc;
        for (int i = 0; i < 12; i++) begin
            set_inputs(0, 0, 0, 1, 1, 1, 0);
            if (out_valid && out_ready) begin
                if (hpc.size() > 0) begin
                    n_chk++; if (prev_pc !== hpc[hpc.size()-1]) begin
                        n_fail++; $display("FAIL stream_prev_pc got=%h exp=%h", prev_pc, hpc[hpc.size()-1]); end
                end
                hpc.push_back(out_pc); hcyc.push_back(cyc);
            end
            advance();
        end
        n_chk++; if (hpc.size() < 5) begin n_fail++; $display("FAIL stream_count got=%0d exp>=5", hpc.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++; if (hpc[i] !== 32'(4 * i) || hcyc[i] !== start + 2 + i) begin
                    n_fail++; $display("FAIL stream_hand%0d got=%h@%0d exp=%h@%0d", i, hpc[i], hcyc[i], 4 * i, start + 2 + i); end
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        repeat (6) begin set_inputs(0, 0, 0, 1, 0, 1, 0); advance(); end
        set_inputs(0, 0, 0, 1, 0, 1, 0);
        n_chk++; if (imem_req_valid !== 1'b0 || pc !== 32'd16) begin
            n_fail++; $display("FAIL full_block got=%b/%h exp=0/10", imem_req_valid, pc); end
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'd0) begin
            n_fail++; $display("FAIL full_head got=%b/%h exp=1/0", out_valid, out_pc); end
        advance();
        set_inputs(0, 0, 0, 1, 1, 1, 0);
        advance();
        set_inputs(0, 0, 0, 1, 0, 1, 0);
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd16) begin
            n_fail++; $display("FAIL full_resume got=%b/%h exp=1/10", imem_req_valid, imem_req_addr); end
        advance();
    endtask

    task automatic test_redirect_inflight();
        bit seen = 0;
        do_reset();
        repeat (2) begin set_inputs(0, 0, 0, 1, 0, 0, 0); advance(); end
        set_inputs(0, 1, 32'h103, 1, 1, 0, 0);
        n_chk++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_cycle got=%b/%b exp=0/0", imem_req_valid, out_valid); end
        advance();
        set_inputs(0, 0, 0, 1, 1, 1, 0);
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_newreq got=%b/%h/%b exp=1/100/0", imem_req_valid, imem_req_addr, out_valid); end
        advance();
        for (int i = 0; i < 20 && !seen; i++) begin
            set_inputs(1, 0, 0, 0, 1, 1, 0);
            if (out_valid) begin
                seen = 1;
                n_chk++; if (out_pc !== 32'h100 || out_instr !== e_out_instr) begin
                    n_fail++; $display("FAIL redir_first got=%h/%h exp=100/%h", out_pc, out_instr, e_out_instr); end
            end
            advance();
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL redir_timeout got=no_output exp=output"); end
    endtask

    task automatic test_redirect_same_rsp();
        do_reset();
        set_inputs(0, 0, 0, 1, 0, 0, 0); advance();
        set_inputs(0, 1, 32'h200, 1, 0, 1, 0);
        n_chk++; if (imem_rsp_valid !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL same_rsp_setup got=%b/%b exp=1/0", imem_rsp_valid, out_valid); end
        advance();
        repeat (3) begin
            set_inputs(1, 0, 0, 0, 0, 1, 0);
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL same_rsp_stale got=%b exp=0", out_valid); end
            advance();
        end
        set_inputs(0, 0, 0, 1, 0, 0, 0);
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            n_fail++; $display("FAIL same_rsp_req got=%b/%h exp=1/200", imem_req_valid, imem_req_addr); end
        advance();
        set_inputs(1, 0, 0, 0, 0, 1, 0); advance();
        set_inputs(1, 0, 0, 0, 0, 1, 0);
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            n_fail++; $display("FAIL same_rsp_fill got=%b/%h exp=1/200", out_valid, out_pc); end
        advance();
    endtask

    task automatic test_stall();
        int ho = 0;
        do_reset();
        repeat (2) begin set_inputs(0, 0, 0, 1, 0, 1, 0); advance(); end
        for (int i = 0; i < 3; i++) begin
            set_inputs(1, 0, 0, 1, i != 0, 1, 0);
            n_chk++; if (imem_req_valid !== 1'b0 || pc !== 32'd8) begin
                n_fail++; $display("FAIL stall_c%0d got=%b/%h exp=0/8", i, imem_req_valid, pc); end
            if (out_valid && out_ready) ho++;
            advance();
        end
        set_inputs(1, 0, 0, 1, 1, 1, 0);
        n_chk++; if (ho !== 2 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_handoffs got=%0d/%b exp=2/0", ho, out_valid); end
        advance();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 40 && m_pc != 32'h40; i++) begin set_inputs(0, 0, 0, 1, 1, 1, 0); advance(); end
        set_inputs(0, 0, 0, 1, 1, 1, 0);
        n_chk++; if (pc !== 32'h40) begin n_fail++; $display("FAIL mid_pre_pc got=%h exp=40", pc); end
        #2; i_rst = 0; #1;
        n_chk++; if (pc !== RESET_PC || prev_pc !== 32'h0 || out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_async got=%h/%h/%b/%b exp=%h/0/0/0", pc, prev_pc, out_valid, imem_req_valid, RESET_PC); end
        model_reset(); idle_inputs();
        @(negedge i_clk); i_rst = 1;
        repeat (2) begin set_inputs(1, 0, 0, 0, 1, 0, 1); advance(); end
        set_inputs(0, 0, 0, 1, 1, 0, 0);
        n_chk++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_fail++; $display("FAIL mid_late_rsp got=%b/%b/%h exp=0/1/%h", out_valid, imem_req_valid, imem_req_addr, RESET_PC); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] rv;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rv = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            set_inputs($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, rv,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 0);
            n_chk++; if (imem_req_valid !== e_req_valid) begin
                n_fail++; $display("FAIL rnd_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, e_req_valid); end
            n_chk++; if (pc !== m_pc || imem_req_addr !== m_pc) begin
                n_fail++; $display("FAIL rnd_pc cyc=%0d got=%h/%h exp=%h", cyc, pc, imem_req_addr, m_pc); end
            n_chk++; if (prev_pc !== m_prev) begin
                n_fail++; $display("FAIL rnd_prev_pc cyc=%0d got=%h exp=%h", cyc, prev_pc, m_prev); end
            n_chk++; if (out_valid !== e_out_valid) begin
                n_fail++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_out_valid); end
            if (e_out_valid) begin
                n_chk++; if (out_pc !== e_out_pc || out_instr !== e_out_instr) begin
                    n_fail++; $display("FAIL rnd_out cyc=%0d got=%h/%h exp=%h/%h", cyc, out_pc, out_instr, e_out_pc, e_out_instr); end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_redirect_inflight();
        test_redirect_same_rsp();
        test_stall();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
